// File: rtl/bsnn_tile_p_if.sv
// bsnn_tile_p_if: start/finish handshake plus data buses of the spiking tile.
// Master side requests an inference; slave side is the tile.
interface bsnn_tile_p_if #(
    parameter int N_IN         = 4,
    parameter int N_NEURONS    = 4,
    parameter int WEIGHT_WIDTH = 2,
    parameter int DTT_WIDTH    = 5,
    parameter int TTD_WIDTH    = 5,
    parameter int POT_WIDTH    = 8
);
    logic                                   start;
    logic [N_IN*DTT_WIDTH-1:0]              input_vector;
    logic [N_NEURONS*N_IN*WEIGHT_WIDTH-1:0] weights;
    logic signed [POT_WIDTH-1:0]            threshold;
    logic                                   busy;
    logic [N_NEURONS*TTD_WIDTH-1:0]         output_vector;
    logic [N_NEURONS-1:0]                   fired;
    logic                                   finish;

    modport master (
        output start, input_vector, weights, threshold,
        input  busy, output_vector, fired, finish
    );

    modport slave (
        input  start, input_vector, weights, threshold,
        output busy, output_vector, fired, finish
    );
endinterface

// File: rtl/bsnn_tile_p.sv
// bsnn_tile_p: time-coded inputs -> LIF neuron array -> first-spike time codes.
// Latency: start cycle 0, finish pulse at cycle 2**DTT_WIDTH+1; start ignored while busy/finishing.
// Optional macro EARLY_FINISH_EN ends the window as soon as every neuron has fired.
module bsnn_tile_p #(
    parameter int N_IN         = 4,
    parameter int N_NEURONS    = 4,
    parameter int WEIGHT_WIDTH = 2,
    parameter int DTT_WIDTH    = 5,
    parameter int TTD_WIDTH    = 5,
    parameter int POT_WIDTH    = 8,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic         CLK,
    input  logic         RST,
    bsnn_tile_p_if.slave bus
);
    localparam int T_MAX   = 2 ** DTT_WIDTH;
    localparam int ACC_W   = POT_WIDTH + WEIGHT_WIDTH + $clog2(N_IN) + 2;
    localparam int CW      = ((DTT_WIDTH > TTD_WIDTH) ? DTT_WIDTH : TTD_WIDTH) + 1;
    localparam int OUT_SAT = 2 ** TTD_WIDTH - 2;
    localparam logic signed [ACC_W-1:0] POT_MAX = ACC_W'(2 ** (POT_WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] POT_MIN = ~POT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                 state_q, state_d;
    logic [DTT_WIDTH-1:0]                   t_q;
    logic [N_IN*DTT_WIDTH-1:0]              iv_q;
    logic [N_NEURONS*N_IN*WEIGHT_WIDTH-1:0] w_q;
    logic signed [POT_WIDTH-1:0]            thr_q;
    logic signed [POT_WIDTH-1:0]            pot_q   [N_NEURONS];
    logic signed [POT_WIDTH-1:0]            pot_nxt [N_NEURONS];
    logic signed [ACC_W-1:0]                acc     [N_NEURONS];
    logic [N_NEURONS-1:0]                   fired_q, fire_now;
    logic [N_NEURONS*TTD_WIDTH-1:0]         out_q;
    logic [N_IN-1:0]                        spike;
    logic [TTD_WIDTH-1:0]                   t_code;
    logic                                   accept, step, go_done, last_step;

    function automatic logic signed [ACC_W-1:0] wext(input logic [WEIGHT_WIDTH-1:0] w);
        logic signed [WEIGHT_WIDTH-1:0] s;
        s = w;
        return ACC_W'(s);
    endfunction

    always_comb begin
        spike = '0;
        for (int i = 0; i < N_IN; i++)
            spike[i] = (t_q == iv_q[i*DTT_WIDTH +: DTT_WIDTH]);
    end

    // The code space reserves all-ones for "never fired", so late spikes clamp one below.
    always_comb begin
        if (CW'(t_q) > CW'(OUT_SAT))
            t_code = TTD_WIDTH'(OUT_SAT);
        else
            t_code = TTD_WIDTH'(t_q);
    end

    always_comb begin
        fire_now = '0;
        for (int j = 0; j < N_NEURONS; j++) begin
            acc[j] = ACC_W'(pot_q[j]);
            if (LEAK_SHIFT > 0)
                acc[j] = acc[j] - (acc[j] >>> LEAK_SHIFT);
            for (int i = 0; i < N_IN; i++)
                if (spike[i])
                    acc[j] = acc[j] + wext(w_q[(j*N_IN+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            if (acc[j] > POT_MAX)
                pot_nxt[j] = POT_MAX[POT_WIDTH-1:0];
            else if (acc[j] < POT_MIN)
                pot_nxt[j] = POT_MIN[POT_WIDTH-1:0];
            else
                pot_nxt[j] = acc[j][POT_WIDTH-1:0];
            fire_now[j] = !fired_q[j] && (pot_nxt[j] >= thr_q);
        end
    end

    assign last_step = (t_q == DTT_WIDTH'(T_MAX - 1));

`ifdef EARLY_FINISH_EN
    logic all_fired;
    assign all_fired = &(fired_q | fire_now);
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        go_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
`ifdef EARLY_FINISH_EN
                go_done = last_step || all_fired;
`else
                go_done = last_step;
`endif
                if (go_done)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            t_q     <= '0;
            iv_q    <= '0;
            w_q     <= '0;
            thr_q   <= '0;
            fired_q <= '0;
            out_q   <= '0;
            for (int j = 0; j < N_NEURONS; j++)
                pot_q[j] <= '0;
        end else if (accept) begin
            t_q     <= '0;
            iv_q    <= bus.input_vector;
            w_q     <= bus.weights;
            thr_q   <= bus.threshold;
            fired_q <= '0;
            out_q   <= '0;
            for (int j = 0; j < N_NEURONS; j++)
                pot_q[j] <= '0;
        end else if (step) begin
            t_q <= t_q + 1'b1;
            for (int j = 0; j < N_NEURONS; j++) begin
                if (fire_now[j]) begin
                    fired_q[j]                        <= 1'b1;
                    out_q[j*TTD_WIDTH +: TTD_WIDTH]   <= t_code;
                    pot_q[j]                          <= '0;
                end else begin
                    pot_q[j] <= pot_nxt[j];
                    // Fill is registered with the last step so results are valid with finish.
                    if (go_done && !fired_q[j])
                        out_q[j*TTD_WIDTH +: TTD_WIDTH] <= '1;
                end
            end
            fired_q <= fired_q | fire_now;
        end
    end

    assign bus.busy          = (state_q == RUN);
    assign bus.finish        = (state_q == DONE);
    assign bus.fired         = fired_q;
    assign bus.output_vector = out_q;
endmodule

// File: tb/tb_bsnn_tile_p.sv
// Bench for bsnn_tile_p: three tiles (LEAK_SHIFT 3, 0, 1) share stimulus and are
// checked against a vector table, hand-written sequences and an arithmetic model.
module tb_bsnn_tile_p;
    localparam int T_MAX = 32;
`ifdef EARLY_FINISH_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [19:0] iv;
        logic [31:0] w;
        logic [7:0]  th;
        logic [19:0] ov;
        logic [3:0]  fd;
        int          fin_full;
        int          fin_early;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [19:0] ivec;
    logic [31:0] wts;
    logic [7:0]  thr;

    int checks = 0;
    int failures = 0;
    int leak_of [3] = '{3, 0, 1};

    logic [19:0] ov_o  [3];
    logic [3:0]  fd_o  [3];
    logic        fin_o [3];
    logic        bsy_o [3];

    int          fin_cyc [3];
    logic [19:0] got_ov  [3];
    logic [3:0]  got_fd  [3];

    bsnn_tile_p_if b0 ();
    bsnn_tile_p_if b1 ();
    bsnn_tile_p_if b2 ();

    assign b0.start = start; assign b0.input_vector = ivec; assign b0.weights = wts; assign b0.threshold = thr;
    assign b1.start = start; assign b1.input_vector = ivec; assign b1.weights = wts; assign b1.threshold = thr;
    assign b2.start = start; assign b2.input_vector = ivec; assign b2.weights = wts; assign b2.threshold = thr;

    assign ov_o[0] = b0.output_vector; assign fd_o[0] = b0.fired; assign fin_o[0] = b0.finish; assign bsy_o[0] = b0.busy;
    assign ov_o[1] = b1.output_vector; assign fd_o[1] = b1.fired; assign fin_o[1] = b1.finish; assign bsy_o[1] = b1.busy;
    assign ov_o[2] = b2.output_vector; assign fd_o[2] = b2.fired; assign fin_o[2] = b2.finish; assign bsy_o[2] = b2.busy;

    bsnn_tile_p #(.LEAK_SHIFT(3)) u0 (.CLK(clk), .RST(rst), .bus(b0));
    bsnn_tile_p #(.LEAK_SHIFT(0)) u1 (.CLK(clk), .RST(rst), .bus(b1));
    bsnn_tile_p #(.LEAK_SHIFT(1)) u2 (.CLK(clk), .RST(rst), .bus(b2));

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", nm, k, act, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Reference: integer walk over the window following the neuron rules directly.
    task automatic model(input int ls, input logic [19:0] iv, input logic [31:0] w, input int th,
                         output logic [19:0] eov, output logic [3:0] efd, output int efin);
        int p [4];
        int tf [4];
        int pn, wv;
        logic [1:0] wb;
        bit all;
        for (int j = 0; j < 4; j++) begin p[j] = 0; tf[j] = -1; end
        efin = T_MAX + 1;
        for (int t = 0; t < T_MAX; t++) begin
            for (int j = 0; j < 4; j++) begin
                pn = (ls > 0) ? p[j] - fdiv(p[j], 1 << ls) : p[j];
                for (int i = 0; i < 4; i++) begin
                    if (int'(iv[i*5 +: 5]) == t) begin
                        wb = w[(j*4+i)*2 +: 2];
                        wv = wb[1] ? int'(wb) - 4 : int'(wb);
                        pn += wv;
                    end
                end
                if (pn > 127) pn = 127;
                if (pn < -128) pn = -128;
                if (tf[j] < 0 && pn >= th) begin tf[j] = t; p[j] = 0; end
                else p[j] = pn;
            end
            all = 1'b1;
            for (int j = 0; j < 4; j++) if (tf[j] < 0) all = 1'b0;
            if (EARLY && all) begin efin = t + 2; break; end
        end
        for (int j = 0; j < 4; j++) begin
            efd[j] = (tf[j] >= 0);
            eov[j*5 +: 5] = (tf[j] < 0) ? 5'd31 : 5'((tf[j] > 30) ? 30 : tf[j]);
        end
    endtask

    // Start one window in the next cycle (cycle 0) and record each tile's first finish.
    task automatic run_window(input logic [19:0] iv, input logic [31:0] w, input logic [7:0] th);
        int cyc;
        bit all;
        for (int k = 0; k < 3; k++) fin_cyc[k] = -1;
        @(negedge clk);
        ivec = iv; wts = w; thr = th; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 100) begin
            all = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (fin_cyc[k] < 0 && fin_o[k]) begin
                    fin_cyc[k] = cyc; got_ov[k] = ov_o[k]; got_fd[k] = fd_o[k];
                end
                if (fin_cyc[k] < 0) all = 1'b0;
            end
            if (all) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [5];
        logic [19:0] riv, eov;
        logic [31:0] rw;
        logic [3:0]  efd;
        int          th_i, efin, tf, got, nf;
        int          nfin [3];
        int          fcyc [3];

        rst = 1'b1; start = 1'b0; ivec = '0; wts = '0; thr = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_ov", k, 32'(ov_o[k]), 32'h0);
            chk("reset_fired", k, 32'(fd_o[k]), 32'h0);
            chk("reset_busy", k, 32'(bsy_o[k]), 32'h0);
            chk("reset_finish", k, 32'(fin_o[k]), 32'h0);
        end
        rst = 1'b0;

        tbl[0] = '{20'h18C63, 32'h55555555, 8'd4,  20'h18C63, 4'hF, 33, 5};
        tbl[1] = '{20'h00000, 32'hAAAAAAAA, 8'd1,  20'hFFFFF, 4'h0, 33, 33};
        tbl[2] = '{20'h00140, 32'h00000005, 8'd2,  20'hFFFEA, 4'h1, 33, 33};
        tbl[3] = '{20'hFFFFF, 32'h55555555, 8'd4,  20'hF7BDE, 4'hF, 33, 33};
        tbl[4] = '{20'h12345, 32'h00000000, 8'hFF, 20'h00000, 4'hF, 33, 2};

        for (int n = 0; n < 5; n++) begin
            run_window(tbl[n].iv, tbl[n].w, tbl[n].th);
            tf = EARLY ? tbl[n].fin_early : tbl[n].fin_full;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("vec%0d_finish_cycle", n), k, 32'(fin_cyc[k]), 32'(tf));
                chk($sformatf("vec%0d_output_vector", n), k, 32'(got_ov[k]), 32'(tbl[n].ov));
                chk($sformatf("vec%0d_fired", n), k, 32'(got_fd[k]), 32'(tbl[n].fd));
            end
        end

        // Start re-pulsed mid-window and on the finish cycle is ignored; cycle 34 is accepted.
        @(negedge clk);
        ivec = tbl[1].iv; wts = tbl[1].w; thr = tbl[1].th; start = 1'b1;
        for (int k = 0; k < 3; k++) begin nfin[k] = 0; fcyc[k] = -1; end
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (fin_o[k]) begin nfin[k]++; fcyc[k] = c; end
                if (c == 34) chk("busy_after_finish", k, 32'(bsy_o[k]), 32'h0);
                if (c == 35) chk("busy_restart", k, 32'(bsy_o[k]), 32'h1);
            end
            start = (c == 5 || c == 33 || c == 34);
        end
        for (int k = 0; k < 3; k++) begin
            chk("single_finish_count", k, 32'(nfin[k]), 32'h1);
            chk("single_finish_cycle", k, 32'(fcyc[k]), 32'd33);
        end
        got = -1;
        for (int c = 36; c < 140; c++) begin
            @(negedge clk);
            if (fin_o[0]) begin got = c; break; end
        end
        chk("restart_finish_cycle", 0, 32'(got), 32'd67);

        // Reset in the middle of a window aborts without a finish.
        @(negedge clk);
        ivec = tbl[2].iv; wts = tbl[2].w; thr = tbl[2].th; start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 12) begin
                for (int k = 0; k < 3; k++) chk("pre_reset_fired", k, 32'(fd_o[k]), 32'h1);
                rst = 1'b1;
            end
            if (c == 13) begin
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk("abort_busy", k, 32'(bsy_o[k]), 32'h0);
                    chk("abort_fired", k, 32'(fd_o[k]), 32'h0);
                    chk("abort_ov", k, 32'(ov_o[k]), 32'h0);
                end
            end
        end
        nf = 0;
        repeat (40) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (fin_o[k]) nf++;
        end
        chk("abort_no_finish", 0, 32'(nf), 32'h0);
        run_window(tbl[2].iv, tbl[2].w, tbl[2].th);
        for (int k = 0; k < 3; k++) begin
            chk("after_abort_finish_cycle", k, 32'(fin_cyc[k]), 32'd33);
            chk("after_abort_ov", k, 32'(got_ov[k]), 32'(tbl[2].ov));
            chk("after_abort_fired", k, 32'(got_fd[k]), 32'(tbl[2].fd));
        end

        // Random windows against the reference model for each leak setting.
        for (int r = 0; r < 20; r++) begin
            riv  = 20'($urandom);
            rw   = $urandom;
            th_i = int'($urandom_range(0, 8)) - 3;
            run_window(riv, rw, 8'(th_i));
            for (int k = 0; k < 3; k++) begin
                model(leak_of[k], riv, rw, th_i, eov, efd, efin);
                chk($sformatf("rand%0d_finish_cycle", r), k, 32'(fin_cyc[k]), 32'(efin));
                chk($sformatf("rand%0d_output_vector", r), k, 32'(got_ov[k]), 32'(eov));
                chk($sformatf("rand%0d_fired", r), k, 32'(got_fd[k]), 32'(efd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
